string_data_memory: RTL
=======================

# string_data_memory

Parametrised data memory for the single-cycle MIPS datapath with byte/halfword/word access and a built-in string-fetch engine for print-string syscalls. The CPU port performs combinational reads and clocked writes. The engine walks a NUL-terminated string from a given address and streams bytes to the console/printer over a valid/ready handshake. It sits between the ALU result bus and the write-back mux, with the syscall unit driving the engine.

## Interface
- ADDR_TOP, 32'h7FFFFFFC: byte address of the highest word (initial stack pointer).
- DEPTH, 256: number of 32-bit words; BASE = ADDR_TOP - 4*(DEPTH-1).
- MAX_STR, 256: maximum characters emitted per string; 1..65535.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memWrite  in  1  write strobe.
- memRead  in  1  read enable.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- address  in  32  byte address.
- writeData  in  32  store data, right-aligned.
- readData  out  32  load data, right-aligned, zero-extended (sign extension is done outside).
- addrError  out  1  combinational: access is out of range or misaligned.
- strStart  in  1  one-cycle request to print the string at strAddr.
- strAddr  in  32  byte address of the first character.
- charOut  out  8  current character.
- charValid  out  1  charOut is valid.
- charReady  in  1  consumer accepts charOut.
- strBusy  out  1  engine is active.
- strDone  out  1  one-cycle pulse at the end of a string.
- strErr  out  1  sticky until the next accepted strStart: engine hit an out-of-range address.
- strLen  out  16  characters accepted for the current or last string.

## Operation
- Storage is DEPTH words, little-endian. Byte lane = address[1:0]. Word index = (address - BASE) >> 2.
- Address is in range iff BASE <= address <= ADDR_TOP+3.
- Alignment:
  - halfword requires address[0]=0;
  - word requires address[1:0]=0.
- Any out-of-range or misaligned access sets addrError for as long as the address and size are applied.
- Reads:
  - readData = selected byte, halfword or word, zero-extended, when memRead=1 and addrError=0.
  - readData = 0 otherwise.
- Writes:
  - On the rising edge with memWrite=1 and addrError=0, only the addressed lanes are updated.
  - Otherwise memory is unchanged.
- Memory contents are not reset and are X until written.
- Engine FSM: IDLE, FETCH, EMIT, DONE.
  - IDLE: strStart=1 latches ptr=strAddr, sets strLen=0, clears strErr, goes to FETCH. strStart in any other state is ignored.
  - FETCH:
    - ptr out of range: strErr=1, go to DONE.
    - byte at ptr is 0: go to DONE.
    - otherwise: register the byte into charOut, set charValid=1, go to EMIT.
  - EMIT: hold charOut and charValid until charReady=1. On the handshake edge: charValid=0, ptr+1, strLen+1. Go to DONE if the new strLen equals MAX_STR, else go to FETCH.
  - DONE: strDone=1 for this cycle, then go to IDLE.
  - strBusy=1 in FETCH, EMIT and DONE.
- The engine reads memory through an independent port. A CPU write to a byte not yet fetched is seen by the engine. A write landing in the same cycle as that byte's FETCH is not seen: the engine gets the old value.
- The terminating NUL is never emitted. An empty string gives strLen=0 and no charValid.

## Timing
- Reset, asynchronous:
  - state=IDLE; charOut=0, charValid=0, strBusy=0, strDone=0, strErr=0, strLen=0, ptr=0.
  - readData and addrError remain combinational.
- Reset mid-string aborts immediately, with no strDone pulse.
- Load latency is 0 cycles, combinational from address/size/memRead. Store becomes visible to reads after the write edge.
- strStart sampled at edge 0:
  - FETCH during cycle 1;
  - charValid high after edge 1;
  - earliest handshake at edge 2.
- Throughput with charReady tied high: 1 character per 2 cycles.
- After a NUL, or after an error detected in FETCH at edge n, strDone is high during cycle n+1. The engine is in IDLE, and can accept a new strStart, from edge n+2.
- Pointer wrap: ptr increments modulo 2^32. Leaving the range ends the string with strErr.

## Test plan
- Write word 0x64636261 at BASE, byte 0x00 at BASE+4, then strStart with strAddr=BASE and charReady=1 -> chars 0x61,0x62,0x63,0x64 at 2-cycle spacing, strDone, strLen=4, strErr=0.
- Byte write 0xAA to ADDR_TOP+1 over word 0x11223344 -> word read 0x1122AA44; halfword read at ADDR_TOP+2 -> 0x00001122.
- Misaligned word access at BASE+2, and address BASE-4 -> addrError=1, readData=0, memory unchanged.
- Hold charReady=0 for 5 cycles on the first char -> charOut stable, charValid high, strLen unchanged; release -> the string continues.
- MAX_STR=3 with a 10-char string -> exactly 3 chars, strLen=3, strDone; a second strStart while busy is ignored.
- Assert rst_n=0 mid-EMIT -> all outputs return to reset values immediately. A new strStart after release runs normally.

Source files
------------

// File: rtl/string_data_memory.sv
// string_data_memory: little-endian data memory with byte/halfword/word CPU access
// and a NUL-terminated string fetch engine streaming bytes over valid/ready.
`default_nettype none

module string_data_memory #(
  parameter logic [31:0] ADDR_TOP = 32'h7FFFFFFC,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned MAX_STR  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  size,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        addrError,
  input  logic        strStart,
  input  logic [31:0] strAddr,
  output logic [7:0]  charOut,
  output logic        charValid,
  input  logic        charReady,
  output logic        strBusy,
  output logic        strDone,
  output logic        strErr,
  output logic [15:0] strLen
);

  localparam logic [31:0] BASE    = ADDR_TOP - 32'(4 * (DEPTH - 1));
  localparam int          IDXW    = $clog2(DEPTH);
  localparam logic [32:0] LO      = {1'b0, BASE};
  localparam logic [32:0] HI      = {1'b0, ADDR_TOP} + 33'd3;
  localparam logic [15:0] MAX_LEN = 16'(MAX_STR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= LO) && ({1'b0, a} <= HI);
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return IDXW'(off);
  endfunction

  logic [31:0] mem_q [DEPTH];

  // CPU port: combinational read, lane-masked clocked write
  logic            misaligned;
  logic [IDXW-1:0] cpu_idx;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_sh;

  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b1111;
    unique case (size)
      2'b00: begin
        misaligned = 1'b0;
        byte_en    = 4'b0001 << address[1:0];
      end
      2'b01: begin
        misaligned = address[0];
        byte_en    = 4'b0011 << address[1:0];
      end
      default: begin
        misaligned = |address[1:0];
        byte_en    = 4'b1111;
      end
    endcase
  end

  assign addrError = !in_range(address) || misaligned;
  assign cpu_idx   = word_idx(address);
  assign rd_word   = mem_q[cpu_idx];
  assign rd_byte   = 8'(rd_word >> {address[1:0], 3'b000});
  assign rd_half   = 16'(rd_word >> {address[1:0], 3'b000});
  assign wdata_sh  = writeData << {address[1:0], 3'b000};

  always_comb begin
    readData = 32'd0;
    if (memRead && !addrError) begin
      unique case (size)
        2'b00:   readData = {24'd0, rd_byte};
        2'b01:   readData = {16'd0, rd_half};
        default: readData = rd_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (memWrite && !addrError) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[cpu_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // String engine: independent read port, sees the pre-edge memory contents
  state_t      state_q;
  logic [31:0] ptr_q;
  logic [7:0]  charOut_q;
  logic        charValid_q;
  logic        strBusy_q;
  logic        strDone_q;
  logic        strErr_q;
  logic [15:0] strLen_q;

  logic [31:0] eng_word;
  logic [7:0]  eng_byte;
  logic        ptr_ok;
  logic [15:0] len_inc;

  assign eng_word = mem_q[word_idx(ptr_q)];
  assign eng_byte = 8'(eng_word >> {ptr_q[1:0], 3'b000});
  assign ptr_ok   = in_range(ptr_q);
  assign len_inc  = strLen_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 32'd0;
      charOut_q   <= 8'd0;
      charValid_q <= 1'b0;
      strBusy_q   <= 1'b0;
      strDone_q   <= 1'b0;
      strErr_q    <= 1'b0;
      strLen_q    <= 16'd0;
    end else begin
      strDone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (strStart) begin
            ptr_q     <= strAddr;
            strLen_q  <= 16'd0;
            strErr_q  <= 1'b0;
            strBusy_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!ptr_ok) begin
            strErr_q  <= 1'b1;
            strDone_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (eng_byte == 8'd0) begin
            strDone_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            charOut_q   <= eng_byte;
            charValid_q <= 1'b1;
            state_q     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (charReady) begin
            charValid_q <= 1'b0;
            ptr_q       <= ptr_q + 32'd1;
            strLen_q    <= len_inc;
            if (len_inc == MAX_LEN) begin
              strDone_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          strBusy_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign charOut   = charOut_q;
  assign charValid = charValid_q;
  assign strBusy   = strBusy_q;
  assign strDone   = strDone_q;
  assign strErr    = strErr_q;
  assign strLen    = strLen_q;

endmodule

`default_nettype wire
